// File: rtl/dec8_to_bin32.sv
// Sequential packed-BCD to binary converter, MSD first, one digit per clock.
// Optional invalid-digit flag `err` is built only when DEC2BIN_ERR_EN is defined.
module dec8_to_bin32 #(
  parameter int N_DIG = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               st,
  input  logic [4*N_DIG-1:0] DEC,
  output logic [31:0]        BIN,
  output logic [2:0]         ptr_dig,
  output logic               en_conv,
  output logic               ok_conv
`ifdef DEC2BIN_ERR_EN
  ,
  output logic               err
`endif
);

  typedef enum logic {IDLE, CONV} state_t;

  state_t             state_q, state_d;
  logic [4*N_DIG-1:0] sr_q, sr_d;
  logic [31:0]        acc_q, acc_d;
  logic [31:0]        bin_q, bin_d;
  logic [2:0]         ptr_q, ptr_d;
  logic               ok_q, ok_d;
  logic [3:0]         digit;
  logic [31:0]        acc_mac;

`ifdef DEC2BIN_ERR_EN
  logic               bad_q, bad_d;
  logic               err_q, err_d;
  logic               bad_now;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      acc_q   <= '0;
      bin_q   <= '0;
      ptr_q   <= '0;
      ok_q    <= 1'b0;
`ifdef DEC2BIN_ERR_EN
      bad_q   <= 1'b0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      acc_q   <= acc_d;
      bin_q   <= bin_d;
      ptr_q   <= ptr_d;
      ok_q    <= ok_d;
`ifdef DEC2BIN_ERR_EN
      bad_q   <= bad_d;
      err_q   <= err_d;
`endif
    end
  end

  // acc*10 + d; wraps to 32 bits if non-BCD nibbles overflow it
  assign digit   = sr_q[4*N_DIG-1 -: 4];
  assign acc_mac = (acc_q << 3) + (acc_q << 1) + {28'd0, digit};

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    acc_d   = acc_q;
    bin_d   = bin_q;
    ptr_d   = ptr_q;
    ok_d    = 1'b0;
`ifdef DEC2BIN_ERR_EN
    bad_now = (digit > 4'd9);
    bad_d   = bad_q;
    err_d   = err_q;
`endif
    if (st) begin
      // start from idle and restart while busy behave identically
      state_d = CONV;
      sr_d    = DEC;
      acc_d   = '0;
      ptr_d   = 3'(N_DIG - 1);
`ifdef DEC2BIN_ERR_EN
      bad_d   = 1'b0;
`endif
    end else if (state_q == CONV) begin
      acc_d = acc_mac;
      sr_d  = sr_q << 4;
`ifdef DEC2BIN_ERR_EN
      bad_d = bad_q | bad_now;
`endif
      if (ptr_q == 3'd0) begin
        state_d = IDLE;
        ok_d    = 1'b1;
        ptr_d   = 3'd0;
`ifdef DEC2BIN_ERR_EN
        err_d   = bad_q | bad_now;
        bin_d   = (bad_q | bad_now) ? 32'd0 : acc_mac;
`else
        bin_d   = acc_mac;
`endif
      end else begin
        ptr_d = ptr_q - 3'd1;
      end
    end
  end

  assign BIN     = bin_q;
  assign ptr_dig = ptr_q;
  assign en_conv = (state_q == CONV);
  assign ok_conv = ok_q;
`ifdef DEC2BIN_ERR_EN
  assign err     = err_q;
`endif

endmodule

// File: tb/tb_dec8_to_bin32.sv
// Self-checking bench for dec8_to_bin32; expected results queued at st, popped at ok_conv.
// Covers both builds of the DEC2BIN_ERR_EN option.
module tb_dec8_to_bin32;

  logic        clk = 1'b0;
  logic        rst;
  logic        st;
  logic [31:0] DEC;
  logic [31:0] BIN;
  logic [2:0]  ptr_dig;
  logic        en_conv;
  logic        ok_conv;
`ifdef DEC2BIN_ERR_EN
  logic        err;
`endif

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  dec8_to_bin32 #(.N_DIG(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .st      (st),
    .DEC     (DEC),
    .BIN     (BIN),
    .ptr_dig (ptr_dig),
    .en_conv (en_conv),
    .ok_conv (ok_conv)
`ifdef DEC2BIN_ERR_EN
    ,
    .err     (err)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [31:0] dec, input logic [31:0] expv);
    DEC = dec;
    st  = 1'b1;
    tick();
    st  = 1'b0;
    exp_q.push_back(expv);
  endtask

  // returns clocks from the st edge to ok_conv, or 0 if none within 20
  task automatic wait_ok(output int lat);
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (ok_conv === 1'b1) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    st  = 1'b0;
    DEC = '0;
    #12;
    checks++;
    if ({BIN, ptr_dig, en_conv, ok_conv} !== {32'd0, 3'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: BIN=%h ptr=%0d en=%b ok=%b, want 0/0/0/0", BIN, ptr_dig, en_conv, ok_conv);
    end
`ifdef DEC2BIN_ERR_EN
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL reset_err: err=%b want 0", err);
    end
`endif
    tick();
    rst = 1'b0;
    tick();
    tick();
    checks++;
    if ({BIN, ptr_dig, en_conv, ok_conv} !== {32'd0, 3'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL idle_state: BIN=%h ptr=%0d en=%b ok=%b, want 0/0/0/0", BIN, ptr_dig, en_conv, ok_conv);
    end
  endtask

  task automatic test_basic;
    logic [31:0] e;
    start(32'h12345678, 32'h00BC614E);
    DEC = 32'hFFFFFFFF;
    for (int j = 0; j < 8; j++) begin
      checks++;
      if (en_conv !== 1'b1 || ok_conv !== 1'b0 || ptr_dig !== 3'(7 - j)) begin
        errors++;
        $display("FAIL busy_step%0d: en=%b ok=%b ptr=%0d, want 1/0/%0d", j, en_conv, ok_conv, ptr_dig, 7 - j);
      end
      if (j < 7) tick();
    end
    tick();
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEADBEEF;
    checks++;
    if (ok_conv !== 1'b1 || en_conv !== 1'b0 || ptr_dig !== 3'd0 || BIN !== e) begin
      errors++;
      $display("FAIL basic_done: ok=%b en=%b ptr=%0d BIN=%h, want 1/0/0/%h", ok_conv, en_conv, ptr_dig, BIN, e);
    end
    tick();
    checks++;
    if (ok_conv !== 1'b0 || BIN !== e) begin
      errors++;
      $display("FAIL basic_hold: ok=%b BIN=%h, want 0/%h", ok_conv, BIN, e);
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    logic [31:0] e;
    start(32'h99999999, 32'h05F5E0FF);
    wait_ok(lat);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEADBEEF;
    checks++;
    if (lat != 8 || BIN !== e) begin
      errors++;
      $display("FAIL max_value: lat=%0d BIN=%h, want 8/%h", lat, BIN, e);
    end
    start(32'h00000000, 32'h00000000);
    wait_ok(lat);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEADBEEF;
    checks++;
    if (lat != 8 || BIN !== e) begin
      errors++;
      $display("FAIL back_to_back: lat=%0d BIN=%h, want 8/%h", lat, BIN, e);
    end
  endtask

  task automatic test_restart;
    int cnt, lat;
    logic stable;
    logic [31:0] prev, got, e;
    prev = BIN;
    start(32'h12345678, 32'h00BC614E);
    tick();
    tick();
    void'(exp_q.pop_back());
    start(32'h00000255, 32'h000000FF);
    cnt = 0; lat = 0; stable = 1'b1; got = '0;
    for (int n = 1; n <= 12; n++) begin
      tick();
      if (ok_conv === 1'b1) begin
        cnt++;
        if (cnt == 1) begin
          lat = n;
          got = BIN;
        end
      end else if (cnt == 0 && BIN !== prev) begin
        stable = 1'b0;
      end
    end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEADBEEF;
    checks++;
    if (cnt != 1 || lat != 8) begin
      errors++;
      $display("FAIL restart_ok: pulses=%0d lat=%0d, want 1/8", cnt, lat);
    end
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL restart_bin: BIN=%h want %h", got, e);
    end
    checks++;
    if (stable !== 1'b1) begin
      errors++;
      $display("FAIL restart_stable: BIN changed before completion, was %h", prev);
    end
  endtask

  task automatic test_bad_digit;
    int lat;
    logic [31:0] e;
`ifdef DEC2BIN_ERR_EN
    start(32'h0000001A, 32'h00000000);
`else
    start(32'h0000001A, 32'h00000014);
`endif
    wait_ok(lat);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEADBEEF;
    checks++;
    if (lat != 8 || BIN !== e) begin
      errors++;
      $display("FAIL bad_digit: lat=%0d BIN=%h, want 8/%h", lat, BIN, e);
    end
`ifdef DEC2BIN_ERR_EN
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL err_set: err=%b want 1", err);
    end
`endif
  endtask

  task automatic test_reset_abort;
    int lat;
    logic [31:0] e;
    start(32'h00000777, 32'h00000309);
    wait_ok(lat);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEADBEEF;
    checks++;
    if (lat != 8 || BIN !== e) begin
      errors++;
      $display("FAIL pre_abort: lat=%0d BIN=%h, want 8/%h", lat, BIN, e);
    end
`ifdef DEC2BIN_ERR_EN
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL err_clear: err=%b want 0", err);
    end
`endif
    start(32'h00000042, 32'h0000002A);
    tick();
    tick();
    tick();
    #2;
    rst = 1'b1;
    void'(exp_q.pop_back());
    #1;
    checks++;
    if ({BIN, ptr_dig, en_conv, ok_conv} !== {32'd0, 3'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL abort_reset: BIN=%h ptr=%0d en=%b ok=%b, want 0/0/0/0", BIN, ptr_dig, en_conv, ok_conv);
    end
    tick();
    rst = 1'b0;
    wait_ok(lat);
    checks++;
    if (lat != 0 || BIN !== 32'd0) begin
      errors++;
      $display("FAIL abort_no_ok: ok after %0d clks, BIN=%h, want none/0", lat, BIN);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_restart();
    test_bad_digit();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
